// File: rtl/dcm_ps_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dcm_ps_responder
//  Function : Cycle-accurate stand-in for the DCM dynamic phase-shift port.
//             Accepts psen/psincdec requests, holds a saturating signed fine
//             phase offset and returns a one-cycle psdone after a fixed
//             shift latency.
//  Revision : 1.0  initial release
// ============================================================================
module dcm_ps_responder #(
    parameter int PS_LATENCY = 12,
    parameter int PS_MIN     = -255,
    parameter int PS_MAX     = 255,
    parameter int PS_W       = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            psen,
    input  logic            psincdec,
    output logic            psdone,
    output logic            ps_busy,
    output logic [PS_W-1:0] ps_value,
    output logic            ps_overflow,
    output logic            protocol_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic signed [PS_W-1:0] MAX_V    = PS_W'(PS_MAX);
    localparam logic signed [PS_W-1:0] MIN_V    = PS_W'(PS_MIN);
    localparam logic signed [PS_W-1:0] ONE_V    = PS_W'(1);
    localparam logic        [7:0]      CNT_LOAD = 8'(PS_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    dir_q, dir_d;
    logic signed [PS_W-1:0]  value_q, value_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    // State, counter and every output are registered; reset aborts any shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            dir_q   <= 1'b0;
            value_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            value_q <= value_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; the offset update is committed on the edge entering DONE
    // so that ps_value and psdone change together.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        value_d = value_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (psen) begin
                    dir_d   = psincdec;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (psen) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 8'd1) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    // Saturation is tested before the add, so the value never wraps.
                    if (dir_q) begin
                        if (value_q < MAX_V) begin
                            value_d = value_q + ONE_V;
                            ovf_d   = 1'b0;
                        end else begin
                            ovf_d   = 1'b1;
                        end
                    end else begin
                        if (value_q > MIN_V) begin
                            value_d = value_q - ONE_V;
                            ovf_d   = 1'b0;
                        end else begin
                            ovf_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                // A request seen here is not queued; it only flags the error.
                if (psen) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign psdone       = done_q;
    assign ps_busy      = busy_q;
    assign ps_value     = value_q;
    assign ps_overflow  = ovf_q;
    assign protocol_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dcm_ps_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcm_ps_responder
//  Function : Self-checking bench for dcm_ps_responder. Two instances (L=12
//             with +/-3 limits, L=2 with +/-2 limits) are compared every edge
//             against a request-timeline reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcm_ps_responder;

    logic clk = 1'b0;
    logic rst;
    logic psen_a, inc_a, psen_b, inc_b;
    logic done_a, busy_a, ovf_a, err_a;
    logic done_b, busy_b, ovf_b, err_b;
    logic signed [8:0] val_a;
    logic signed [3:0] val_b;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per instance, whether a request is in flight and how
    // many edges have elapsed since it was accepted.
    int m_lat [2] = '{12, 2};
    int m_max [2] = '{3, 2};
    int m_min [2] = '{-3, -2};
    int m_act [2];
    int m_t   [2];
    int m_dir [2];
    int m_val [2];
    int m_ovf [2];
    int m_err [2];

    always #5 clk = ~clk;

    dcm_ps_responder #(.PS_LATENCY(12), .PS_MIN(-3), .PS_MAX(3), .PS_W(9)) u_dut_a (
        .clk(clk), .rst(rst), .psen(psen_a), .psincdec(inc_a),
        .psdone(done_a), .ps_busy(busy_a), .ps_value(val_a),
        .ps_overflow(ovf_a), .protocol_err(err_a)
    );

    dcm_ps_responder #(.PS_LATENCY(2), .PS_MIN(-2), .PS_MAX(2), .PS_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .psen(psen_b), .psincdec(inc_b),
        .psdone(done_b), .ps_busy(busy_b), .ps_value(val_b),
        .ps_overflow(ovf_b), .protocol_err(err_b)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t[i] = 0; m_dir[i] = 0;
            m_val[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input logic p, input logic d);
        if (m_act[i] != 0) begin
            if (p) m_err[i] = 1;
            m_t[i]++;
            if (m_t[i] == m_lat[i] - 1) begin
                if (m_dir[i] != 0) begin
                    if (m_val[i] < m_max[i]) begin m_val[i]++; m_ovf[i] = 0; end
                    else m_ovf[i] = 1;
                end else begin
                    if (m_val[i] > m_min[i]) begin m_val[i]--; m_ovf[i] = 0; end
                    else m_ovf[i] = 1;
                end
            end
            if (m_t[i] == m_lat[i]) m_act[i] = 0;
        end else if (p) begin
            m_act[i] = 1;
            m_t[i]   = 0;
            m_dir[i] = d ? 1 : 0;
        end
    endtask

    // Advance the model on every edge (or reset) and compare all outputs shortly after.
    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0, psen_a, inc_a);
            model_step(1, psen_b, inc_b);
        end
        #1;
        check("A.busy", busy_a, m_act[0]);
        check("A.done", done_a, (m_act[0] != 0 && m_t[0] == m_lat[0] - 1) ? 1 : 0);
        check("A.value", val_a, m_val[0]);
        check("A.ovf", ovf_a, m_ovf[0]);
        check("A.err", err_a, m_err[0]);
        check("B.busy", busy_b, m_act[1]);
        check("B.done", done_b, (m_act[1] != 0 && m_t[1] == m_lat[1] - 1) ? 1 : 0);
        check("B.value", val_b, m_val[1]);
        check("B.ovf", ovf_b, m_ovf[1]);
        check("B.err", err_b, m_err[1]);
    end

    // Called at a falling edge: request sampled at the next rising edge, next
    // call's request lands 'gap' edges later. Direction is scrambled after capture.
    task automatic do_req(input int i, input logic d, input int gap);
        if (i == 0) begin psen_a = 1'b1; inc_a = d; end
        else        begin psen_b = 1'b1; inc_b = d; end
        @(negedge clk);
        if (i == 0) begin psen_a = 1'b0; inc_a = 1'($urandom); end
        else        begin psen_b = 1'b0; inc_b = 1'($urandom); end
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int sat_v [5] = '{1, 2, 3, 3, 3};
    int sat_o [5] = '{0, 0, 0, 1, 1};

    initial begin
        rst = 1'b1;
        psen_a = 1'b0; inc_a = 1'b0; psen_b = 1'b0; inc_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single decrement
        do_req(0, 1'b0, 13);
        check("single.value", val_a, -1);
        check("single.err", err_a, 0);

        // Saturation against +3, then a decrement out of saturation
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            do_req(0, 1'b1, 13);
            check("sat.value", val_a, sat_v[k]);
            check("sat.ovf", ovf_a, sat_o[k]);
        end
        do_req(0, 1'b0, 13);
        check("sat.dec_value", val_a, 2);
        check("sat.dec_ovf", ovf_a, 0);

        // Busy violation: extra requests at edge 5 and in the DONE cycle
        reset_dut();
        do_req(0, 1'b1, 5);
        do_req(0, 1'b0, 7);
        do_req(0, 1'b0, 20);
        check("busyviol.value", val_a, 1);
        check("busyviol.err", err_a, 1);

        // Back-to-back at minimum spacing
        reset_dut();
        do_req(0, 1'b0, 13);
        do_req(0, 1'b0, 13);
        check("b2b.value", val_a, -2);
        check("b2b.err", err_a, 0);

        // Reset mid-shift, between edges 6 and 7
        do_req(0, 1'b1, 7);
        #2 rst = 1'b1;
        #1;
        check("midrst.busy", busy_a, 0);
        check("midrst.value", val_a, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        do_req(0, 1'b1, 13);
        check("midrst.after", val_a, 1);

        // Minimum latency instance
        reset_dut();
        do_req(1, 1'b1, 3);
        check("minlat.value", val_b, 1);
        do_req(1, 1'b1, 3);
        check("minlat.value2", val_b, 2);
        check("minlat.err", err_b, 0);

        // Randomized traffic on both instances with occasional async reset
        reset_dut();
        repeat (3000) begin
            @(negedge clk);
            psen_a = ($urandom_range(0, 5) == 0);
            inc_a  = 1'($urandom);
            psen_b = ($urandom_range(0, 2) == 0);
            inc_b  = 1'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                @(posedge clk);
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        psen_a = 1'b0; psen_b = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
